// File: rtl/dma_channel_scheduler.sv
// DMA channel scheduler: picks the highest-priority pending enabled channel (round-robin among ties)
// and hands it to the shared DMA engine. Optional busy watchdog: define DMA_SCHED_TIMEOUT_EN.
module dma_channel_scheduler #(
  parameter int CHANNELS_AMOUNT = 4,
  parameter int CH_W            = (CHANNELS_AMOUNT > 1) ? $clog2(CHANNELS_AMOUNT) : 1,
  parameter int TIMEOUT_W       = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CHANNELS_AMOUNT-1:0]   request_i,
  input  logic [CHANNELS_AMOUNT-1:0]   ch_enable_i,
  input  logic [2*CHANNELS_AMOUNT-1:0] priority_i,
  input  logic [TIMEOUT_W-1:0]         timeout_cycles_i,
  output logic                         grant_valid_o,
  output logic [CH_W-1:0]              grant_channel_o,
  input  logic                         engine_ready_i,
  input  logic                         engine_done_i,
  output logic [CHANNELS_AMOUNT-1:0]   acknowledge_o,
  output logic                         busy_o,
  output logic                         error_o,
  output logic [2:0]                   state_dbg_o
);

  // Handshake: the grant transfers on a cycle with grant_valid_o && engine_ready_i;
  // once raised, grant_valid_o and grant_channel_o stay fixed until that transfer.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_GRANT = 3'd2,
    S_BUSY  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t                       state_q;
  logic                         grant_valid_q;
  logic                         busy_q;
  logic [CH_W-1:0]              grant_ch_q;
  logic [CH_W-1:0]              rr_q;
  logic [CHANNELS_AMOUNT-1:0]   ack_q;

  logic [CHANNELS_AMOUNT-1:0]   elig;
  logic [1:0]                   prio_a [CHANNELS_AMOUNT];
  logic [1:0]                   max_prio;
  logic [CH_W-1:0]              pick_d;
  logic [CH_W-1:0]              rr_d;
  logic [CHANNELS_AMOUNT-1:0]   ack_d;
  logic [CH_W-1:0]              idx_w;
  int                           idx;
  logic                         found;

  assign elig = request_i & ch_enable_i;

  always_comb begin
    for (int c = 0; c < CHANNELS_AMOUNT; c++) prio_a[c] = priority_i[2*c +: 2];
  end

  always_comb begin
    max_prio = 2'd0;
    for (int c = 0; c < CHANNELS_AMOUNT; c++) begin
      if (elig[c] && (prio_a[c] > max_prio)) max_prio = prio_a[c];
    end
  end

  // Scan upward from the round-robin pointer; first eligible channel at the top level wins.
  always_comb begin
    pick_d = '0;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 0; k < CHANNELS_AMOUNT; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= CHANNELS_AMOUNT) idx = idx - CHANNELS_AMOUNT;
      idx_w = idx[CH_W-1:0];
      if (!found && elig[idx_w] && (prio_a[idx_w] == max_prio)) begin
        pick_d = idx_w;
        found  = 1'b1;
      end
    end
  end

  assign rr_d = (grant_ch_q == CH_W'(CHANNELS_AMOUNT - 1)) ? '0 : grant_ch_q + CH_W'(1);

  always_comb begin
    ack_d             = '0;
    ack_d[grant_ch_q] = 1'b1;
  end

`ifdef DMA_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 err_q;
  logic                 timeout_hit;

  // A limit of zero disables the watchdog.
  assign timeout_hit = (timeout_cycles_i != '0) &&
                       ((cnt_q + TIMEOUT_W'(1)) == timeout_cycles_i);
  assign error_o     = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles_i;
  assign error_o        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      grant_valid_q <= 1'b0;
      grant_ch_q    <= '0;
      busy_q        <= 1'b0;
      ack_q         <= '0;
      rr_q          <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (|elig) state_q <= S_ARB;
        end
        S_ARB: begin
          if (|elig) begin
            grant_ch_q    <= pick_d;
            grant_valid_q <= 1'b1;
            state_q       <= S_GRANT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (engine_ready_i) begin
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_BUSY;
`ifdef DMA_SCHED_TIMEOUT_EN
            cnt_q         <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (engine_done_i) begin
            busy_q  <= 1'b0;
            ack_q   <= ack_d;
            state_q <= S_ACK;
          end
`ifdef DMA_SCHED_TIMEOUT_EN
          else if (timeout_hit) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            rr_q    <= rr_d;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
          end
`endif
        end
        S_ACK: begin
          rr_q    <= rr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_valid_o   = grant_valid_q;
  assign grant_channel_o = grant_ch_q;
  assign acknowledge_o   = ack_q;
  assign busy_o          = busy_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Bench for dma_channel_scheduler: directed transfers checked against a transaction-level
// timeline model every cycle, plus literal checks on latency, ordering and reset behaviour.
module tb_dma_channel_scheduler;
  localparam int N    = 4;
  localparam int CH_W = 2;
  localparam int TW   = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic [N-1:0]    request_i = '0;
  logic [N-1:0]    ch_enable_i = '0;
  logic [2*N-1:0]  priority_i = '0;
  logic [TW-1:0]   timeout_cycles_i = '0;
  logic            engine_ready_i = 1'b0;
  logic            engine_done_i = 1'b0;
  logic            grant_valid_o;
  logic [CH_W-1:0] grant_channel_o;
  logic [N-1:0]    acknowledge_o;
  logic            busy_o;
  logic            error_o;
  logic [2:0]      state_dbg_o;

  dma_channel_scheduler #(.CHANNELS_AMOUNT(N), .TIMEOUT_W(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .request_i(request_i), .ch_enable_i(ch_enable_i),
    .priority_i(priority_i), .timeout_cycles_i(timeout_cycles_i),
    .grant_valid_o(grant_valid_o), .grant_channel_o(grant_channel_o),
    .engine_ready_i(engine_ready_i), .engine_done_i(engine_done_i),
    .acknowledge_o(acknowledge_o), .busy_o(busy_o), .error_o(error_o),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [CH_W-1:0] exp_q[$];
  logic [N-1:0]    one = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic            m_valid = 1'b0;
  logic            m_busy  = 1'b0;
  logic            m_err   = 1'b0;
  logic [CH_W-1:0] m_ch    = '0;
  logic [N-1:0]    m_ack   = '0;
  int              m_rr    = 0;

  function automatic int pick(input logic [N-1:0] e, input logic [2*N-1:0] p, input int r);
    int best = -1;
    int idx;
    for (int i = 0; i < N; i++)
      if (e[i] && int'(p[2*i +: 2]) > best) best = int'(p[2*i +: 2]);
    for (int k = 0; k < N; k++) begin
      idx = (r + k) % N;
      if (e[idx] && int'(p[2*idx +: 2]) == best) return idx;
    end
    return 0;
  endfunction

  // One transfer = wait eligible, arbitrate, offer, hold busy, acknowledge (or abort).
  task automatic model_run();
    int ch;
    int n;
    forever begin
      do begin
        @(posedge clk_i);
        if (!rst_i) return;
        m_err = 1'b0;
        m_ack = '0;
      end while ((request_i & ch_enable_i) == '0);
      @(posedge clk_i);
      if (!rst_i) return;
      if ((request_i & ch_enable_i) == '0) continue;
      ch      = pick(request_i & ch_enable_i, priority_i, m_rr);
      m_valid = 1'b1;
      m_ch    = ch[CH_W-1:0];
      do begin
        @(posedge clk_i);
        if (!rst_i) return;
      end while (!engine_ready_i);
      m_valid = 1'b0;
      m_busy  = 1'b1;
      n       = 0;
      forever begin
        @(posedge clk_i);
        if (!rst_i) return;
        n++;
        if (engine_done_i) begin
          m_busy = 1'b0;
          m_ack  = one << ch;
          m_rr   = (ch + 1) % N;
          @(posedge clk_i);
          if (!rst_i) return;
          m_ack = '0;
          break;
        end
`ifdef DMA_SCHED_TIMEOUT_EN
        if (timeout_cycles_i != '0 && n == int'(timeout_cycles_i)) begin
          m_busy = 1'b0;
          m_err  = 1'b1;
          m_rr   = (ch + 1) % N;
          break;
        end
`endif
      end
    end
  endtask

  initial begin
    forever begin
      wait (rst_i === 1'b1);
      m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_ack = '0; m_ch = '0; m_rr = 0;
      model_run();
      wait (rst_i === 1'b0);
    end
  end

  // Per-cycle compare, #1 after the active edge; while in reset every output must be 0.
  always @(posedge clk_i) begin
    #1;
    check("cyc_grant_valid", 32'(grant_valid_o), rst_i ? 32'(m_valid) : 32'd0);
    check("cyc_busy",        32'(busy_o),        rst_i ? 32'(m_busy)  : 32'd0);
    check("cyc_ack",         32'(acknowledge_o), rst_i ? 32'(m_ack)   : 32'd0);
    check("cyc_error",       32'(error_o),       rst_i ? 32'(m_err)   : 32'd0);
    if (rst_i && m_valid) check("cyc_grant_channel", 32'(grant_channel_o), 32'(m_ch));
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_grant();
    int t = 0;
    while (grant_valid_o !== 1'b1 && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    check("grant_seen", 32'(grant_valid_o), 32'd1);
  endtask

  // Engine ready is held high: accept next edge, done one cycle later, ack one cycle after that.
  task automatic do_xfer(input bit drop);
    logic [CH_W-1:0] e;
    e = exp_q.pop_front();
    wait_grant();
    check("xfer_channel", 32'(grant_channel_o), 32'(e));
    if (drop) request_i[e] = 1'b0;
    step(1);
    engine_done_i = 1'b1;
    step(1);
    engine_done_i = 1'b0;
    check("xfer_ack", 32'(acknowledge_o), 32'(one << e));
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(3);
    check("reset_grant_valid", 32'(grant_valid_o), 32'd0);
    check("reset_grant_channel", 32'(grant_channel_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_ack", 32'(acknowledge_o), 32'd0);
    rst_i = 1'b1;
    step(1);

    // Single request on channel 0, done 5 cycles after acceptance.
    ch_enable_i    = 4'b0001;
    engine_ready_i = 1'b1;
    request_i      = 4'b0001;
    step(1);
    check("t1_no_grant_after_1", 32'(grant_valid_o), 32'd0);
    step(1);
    check("t1_grant_after_2", 32'(grant_valid_o), 32'd1);
    check("t1_channel", 32'(grant_channel_o), 32'd0);
    request_i = 4'b0000;
    step(1);
    check("t1_busy", 32'(busy_o), 32'd1);
    step(4);
    engine_done_i = 1'b1;
    step(1);
    engine_done_i = 1'b0;
    check("t1_ack", 32'(acknowledge_o), 32'b0001);
    check("t1_busy_low", 32'(busy_o), 32'd0);
    step(1);
    check("t1_ack_one_cycle", 32'(acknowledge_o), 32'd0);

    // Priority: ch3 (prio 3) beats ch1 (prio 1).
    ch_enable_i = 4'b1111;
    priority_i  = 8'b11_00_01_00;
    request_i   = 4'b1010;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    do_xfer(1'b1);
    do_xfer(1'b1);

    // Round-robin among equal priorities, including wrap from 3 to 0.
    pulse_reset();
    priority_i = 8'b10_10_10_10;
    request_i  = 4'b1111;
    for (int i = 0; i < 8; i++) exp_q.push_back(CH_W'(i % N));
    for (int i = 0; i < 8; i++) do_xfer(1'b0);
    request_i = 4'b0000;

    // Backpressure: request dropped while offered, grant must hold.
    step(2);
    engine_ready_i = 1'b0;
    request_i      = 4'b0100;
    wait_grant();
    check("t4_channel", 32'(grant_channel_o), 32'd2);
    request_i = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t4_hold_valid", 32'(grant_valid_o), 32'd1);
      check("t4_hold_channel", 32'(grant_channel_o), 32'd2);
    end
    engine_ready_i = 1'b1;
    step(1);
    check("t4_busy", 32'(busy_o), 32'd1);
    check("t4_valid_dropped", 32'(grant_valid_o), 32'd0);
    engine_done_i = 1'b1;
    step(1);
    engine_done_i = 1'b0;
    check("t4_ack", 32'(acknowledge_o), 32'b0100);

    // Disabled channel never granted.
    ch_enable_i = 4'b1110;
    request_i   = 4'b0001;
    step(6);
    check("disabled_no_grant", 32'(grant_valid_o), 32'd0);
    request_i   = 4'b0000;
    ch_enable_i = 4'b1111;
    step(2);

    // Async reset mid-BUSY; later done ignored; pointer restarts at channel 0.
    request_i = 4'b0010;
    wait_grant();
    check("t5_channel", 32'(grant_channel_o), 32'd1);
    request_i = 4'b0000;
    step(1);
    check("t5_busy", 32'(busy_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy_o), 32'd0);
    check("t5_rst_valid", 32'(grant_valid_o), 32'd0);
    check("t5_rst_ack", 32'(acknowledge_o), 32'd0);
    check("t5_rst_error", 32'(error_o), 32'd0);
    step(1);
    rst_i = 1'b1;
    step(1);
    engine_done_i = 1'b1;
    step(1);
    engine_done_i = 1'b0;
    check("t5_done_ignored_ack", 32'(acknowledge_o), 32'd0);
    check("t5_done_ignored_busy", 32'(busy_o), 32'd0);
    request_i = 4'b1111;
    exp_q.push_back(2'd0);
    do_xfer(1'b0);
    request_i = 4'b0000;
    step(2);

`ifdef DMA_SCHED_TIMEOUT_EN
    // Watchdog: no done, error 20 cycles after BUSY entry, then next pending channel.
    timeout_cycles_i = 16'd20;
    request_i        = 4'b0011;
    wait_grant();
    check("t6_channel", 32'(grant_channel_o), 32'd1);
    request_i[1] = 1'b0;
    step(20);
    check("t6_no_error_early", 32'(error_o), 32'd0);
    step(1);
    check("t6_error", 32'(error_o), 32'd1);
    check("t6_no_ack", 32'(acknowledge_o), 32'd0);
    check("t6_busy_low", 32'(busy_o), 32'd0);
    step(1);
    check("t6_error_one_cycle", 32'(error_o), 32'd0);
    exp_q.push_back(2'd0);
    do_xfer(1'b1);
    timeout_cycles_i = '0;
    step(2);
`endif

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_channel_scheduler.md
Name: dma_channel_scheduler

Overview:
- Arbitrates the single shared DMA engine between CHANNELS_AMOUNT peripheral request lines.
- Selects the highest-priority pending enabled channel and round-robins among ties.
- Presents the grant to the engine with a valid/ready handshake, then holds that channel busy until the engine reports completion.
- Returns a one-cycle acknowledge pulse to the requesting peripheral; sits between the peripheral request pins, the CSR block and dma_controller_engine.

Parameters:
CHANNELS_AMOUNT, 4, number of DMA channels (1..16)
CH_W, (CHANNELS_AMOUNT>1 ? $clog2(CHANNELS_AMOUNT) : 1), channel index width (derived, do not override)
TIMEOUT_W, 16, width of busy watchdog counter (used only with DMA_SCHED_TIMEOUT_EN)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  asynchronous reset, active-low
request_i  input  CHANNELS_AMOUNT  level request per channel from peripheral
ch_enable_i  input  CHANNELS_AMOUNT  CSR channel enable
priority_i  input  2*CHANNELS_AMOUNT  CSR priority per channel, bits [2c+1:2c], 3 = highest
timeout_cycles_i  input  TIMEOUT_W  CSR watchdog limit (ignored without the macro)
grant_valid_o  output  1  grant offered to engine
grant_channel_o  output  CH_W  granted channel index
engine_ready_i  input  1  engine accepts grant when high with grant_valid_o
engine_done_i  input  1  one-cycle pulse, active transfer finished
acknowledge_o  output  CHANNELS_AMOUNT  one-hot one-cycle acknowledge to peripheral
busy_o  output  1  high from grant acceptance until acknowledge issued
error_o  output  1  one-cycle pulse on watchdog abort (tied 0 without macro)

Behaviour:
- Reset (rst_i low, async): state IDLE; grant_valid_o=0, grant_channel_o=0, acknowledge_o=0, busy_o=0, error_o=0; rr pointer=0; watchdog counter=0.
- Eligible mask = request_i & ch_enable_i, sampled in IDLE.
- States:
  - IDLE: eligible mask nonzero -> ARB; otherwise stay.
  - ARB: take the maximum priority among eligible channels. Among channels at that level, pick the first index at or after rr pointer, scanning upward modulo CHANNELS_AMOUNT. Register the pick into grant_channel_o; -> GRANT. If the mask has become zero, -> IDLE.
  - GRANT: grant_valid_o=1; grant_channel_o held stable. On engine_ready_i=1 -> BUSY, busy_o=1 from the next cycle. No retraction: request_i or ch_enable_i deasserting in GRANT does not drop the grant.
  - BUSY: wait for engine_done_i -> ACK.
  - ACK: acknowledge_o[grant_channel_o]=1 for exactly this cycle; busy_o=0; rr pointer = grant_channel_o+1 modulo CHANNELS_AMOUNT; -> IDLE.
- Latency: request_i rising in IDLE gives grant_valid_o high 2 cycles later. engine_done_i gives acknowledge_o 1 cycle later. Minimum 1 idle cycle between consecutive grants.
- Ignored inputs:
  - engine_done_i outside BUSY.
  - engine_ready_i outside GRANT.
  - CSR changes during GRANT, BUSY or ACK; they take effect at the next ARB.
- Wrap-around: rr pointer at CHANNELS_AMOUNT-1 with the grant on the last channel wraps to 0.
- CHANNELS_AMOUNT=1: grant_channel_o constant 0; arbitration degenerates to a pass-through of the eligible bit.
- grant_valid_o and acknowledge_o are registered outputs, never combinational from inputs.

Optional Feature:
- Macro: DMA_SCHED_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to BUSY, increments each BUSY cycle.
  - If it reaches timeout_cycles_i before engine_done_i: error_o pulses 1 cycle, no acknowledge, rr pointer advances as in ACK, state -> IDLE.
  - timeout_cycles_i=0 disables the watchdog.
  - engine_done_i in the same cycle as the timeout wins: normal ACK, no error.
- Undefined: no counter logic, error_o tied 0, timeout_cycles_i unused.

Test Plan:
- Single request: enable=4'b0001, request_i[0] rises, ready held 1, done 5 cycles after acceptance -> grant_valid_o at +2 cycles with channel 0, acknowledge_o=4'b0001 for 1 cycle after done, busy_o low after.
- Priority: ch1 prio 1, ch3 prio 3, both requesting -> ch3 granted first, ch1 second.
- Round-robin: all 4 channels prio 2, requests held high, 8 transfers -> grant order 0,1,2,3,0,1,2,3.
- Backpressure/no retraction: engine_ready_i low 10 cycles, request_i[2] dropped in GRANT -> grant_valid_o stays 1 with channel 2 until ready, then BUSY.
- Async reset mid-BUSY: rst_i low for 1 cycle -> all outputs 0 immediately; later done pulse ignored; next grant starts from channel 0.
- With DMA_SCHED_TIMEOUT_EN, timeout_cycles_i=20, no done -> error_o pulse exactly 20 cycles after entering BUSY, no acknowledge, next pending channel granted.
